alu_share_arbiter: RTL and testbench
====================================

// Module: alu_share_arbiter
// PURPOSE
//   Shares the single combinational RV32 ALU between two requesters:
//   req0 = execute stage, req1 = address-gen/branch unit.
//   Picks at most one request per cycle (round-robin on conflict) and drives the ALU.
//   Captures alu_result into a per-requester response register.
//   Holds each response until the owner accepts it. Sits between the decode/execute
//   control and the ALU; alu_op uses the 4-bit ALU opcode encoding.
// PARAMETERS
//   DATA_W   32  operand/result width
//   OP_W     4   ALU opcode width
//   CNT_W    16  width of the saturating conflict counter
// PORTS
//   clk           in   1       rising-edge clock
//   reset         in   1       asynchronous, active-high reset
//   reqN_valid    in   1       (N=0,1) request present
//   reqN_ready    out  1       request accepted this cycle when valid&ready
//   reqN_op       in   OP_W    ALU opcode
//   reqN_a        in   DATA_W  operand A
//   reqN_b        in   DATA_W  operand B
//   rspN_valid    out  1       result held for requester N
//   rspN_ready    in   1       requester N consumes result
//   rspN_data     out  DATA_W  captured result
//   alu_op        out  OP_W    to ALU
//   alu_a         out  DATA_W  to ALU
//   alu_b         out  DATA_W  to ALU
//   alu_result    in   DATA_W  from ALU (combinational, same cycle)
//   conflict_cnt  out  CNT_W   cycles where both requesters were eligible
// BEHAVIOUR
// - Reset (async):
//   - rsp0_valid=rsp1_valid=0, rsp*_data=0, conflict_cnt=0.
//   - last_grant=1, so req0 wins the first conflict.
//   - Pending responses and in-flight requests are discarded.
// - Slot free: slotN_free = !rspN_valid | rspN_ready. A slot that is draining this
//   cycle can accept a new request.
// - Eligibility: eligN = reqN_valid & slotN_free.
// - Grant (combinational, one-hot or none):
//   - Only one requester eligible: grant it.
//   - Both eligible: grant the one != last_grant.
//   - Neither eligible: no grant.
// - reqN_ready = grantN. Ready depends on reqN_valid; requesters must not wait on
//   ready before asserting valid.
// - ALU drive:
//   - With a grant: alu_op/a/b = the granted requester's op/a/b.
//   - With no grant: alu_op=4'b0000, alu_a=0, alu_b=0 (quiet add).
// - Capture: at the edge where grantN=1, rspN_data <= alu_result, rspN_valid <= 1,
//   last_grant <= N.
// - Latency: 1 cycle, request accepted at edge k, result visible after edge k.
// - Clearing a response: rspN_valid & rspN_ready with no new grantN gives
//   rspN_valid <= 0. Same edge with a new grantN gives rspN_valid stays 1 and the
//   data is replaced. Full throughput is one op per requester per cycle when uncontended.
// - rspN_data is stable while rspN_valid & !rspN_ready.
// - last_grant updates only on a grant; an idle cycle does not change the order.
// - conflict_cnt increments on each cycle with elig0&elig1 and saturates at all-ones,
//   no wrap.
// - Requester 1 blocked only by its own full slot never stalls requester 0, and vice versa.
// - No combinational path from rspN_ready to alu_* other than through grant eligibility.
// TESTING
// - Single request: req0 op=0000, a=5, b=7, rsp0_ready=1
//   -> req0_ready=1, alu_a=5, alu_b=7; next cycle rsp0_valid=1, rsp0_data=12.
// - Conflict after reset: both valid every cycle with both rsp_ready=1
//   -> grants 0,1,0,1...; conflict_cnt increments each cycle.
// - Backpressure: rsp1_ready=0 with rsp1 held -> req1_ready=0, rsp1_data stable;
//   req0 still granted each cycle.
// - Drain+refill: rsp0_valid=1, rsp0_ready=1, req0 valid op=0001 a=9 b=4
//   -> same edge rsp0_data=5, rsp0_valid stays 1.
// - Idle: no valid -> alu_op=0000, alu_a=alu_b=0; last_grant unchanged.
// - Saturation and reset: CNT_W=4 with 20 conflict cycles -> conflict_cnt=15.
//   Reset asserted with rsp1_valid=1 -> all rsp_valid=0 immediately, counter=0.

Source files
------------

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter
//   Shares one combinational ALU between two requesters (0 = execute stage,
//   1 = address-gen/branch unit). At most one request is granted per cycle, with
//   round-robin order on conflict. The ALU result is captured into a per-requester
//   response register that is held until its owner accepts it.
// Ports
//   clk, reset                      rising-edge clock, async active-high reset
//   reqN_valid/ready/op/a/b         request handshake and operands (N = 0,1)
//   rspN_valid/ready/data           response handshake and captured result
//   alu_op/alu_a/alu_b              drive to the shared ALU (zero when idle)
//   alu_result                      combinational result from the ALU
//   conflict_cnt                    saturating count of cycles with both eligible
module alu_share_arbiter #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned OP_W   = 4,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [OP_W-1:0]   req0_op,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [OP_W-1:0]   req1_op,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  output logic              rsp0_valid,
  input  logic              rsp0_ready,
  output logic [DATA_W-1:0] rsp0_data,
  output logic              rsp1_valid,
  input  logic              rsp1_ready,
  output logic [DATA_W-1:0] rsp1_data,
  output logic [OP_W-1:0]   alu_op,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  input  logic [DATA_W-1:0] alu_result,
  output logic [CNT_W-1:0]  conflict_cnt
);

  logic              rsp0_valid_q, rsp0_valid_d;
  logic              rsp1_valid_q, rsp1_valid_d;
  logic [DATA_W-1:0] rsp0_data_q, rsp0_data_d;
  logic [DATA_W-1:0] rsp1_data_q, rsp1_data_d;
  logic              last_grant_q, last_grant_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic slot0_free, slot1_free;
  logic elig0, elig1;
  logic grant0, grant1;

  // A slot draining this cycle may be refilled on the same edge.
  assign slot0_free = !rsp0_valid_q || rsp0_ready;
  assign slot1_free = !rsp1_valid_q || rsp1_ready;
  assign elig0      = req0_valid && slot0_free;
  assign elig1      = req1_valid && slot1_free;

  // Grant: lone eligible requester wins; on conflict the one that did not win last.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (elig0 && elig1) begin
      grant0 = last_grant_q;
      grant1 = !last_grant_q;
    end else begin
      grant0 = elig0;
      grant1 = elig1;
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;

  // Idle drive is a quiet add of zeros so the ALU inputs do not toggle.
  always_comb begin
    alu_op = '0;
    alu_a  = '0;
    alu_b  = '0;
    if (grant0) begin
      alu_op = req0_op;
      alu_a  = req0_a;
      alu_b  = req0_b;
    end else if (grant1) begin
      alu_op = req1_op;
      alu_a  = req1_a;
      alu_b  = req1_b;
    end
  end

  always_comb begin
    rsp0_valid_d = rsp0_valid_q;
    rsp0_data_d  = rsp0_data_q;
    rsp1_valid_d = rsp1_valid_q;
    rsp1_data_d  = rsp1_data_q;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q;

    if (grant0) begin
      rsp0_valid_d = 1'b1;
      rsp0_data_d  = alu_result;
      last_grant_d = 1'b0;
    end else if (rsp0_ready) begin
      rsp0_valid_d = 1'b0;
    end

    if (grant1) begin
      rsp1_valid_d = 1'b1;
      rsp1_data_d  = alu_result;
      last_grant_d = 1'b1;
    end else if (rsp1_ready) begin
      rsp1_valid_d = 1'b0;
    end

    if (elig0 && elig1 && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
      rsp0_data_q  <= '0;
      rsp1_data_q  <= '0;
      last_grant_q <= 1'b1;  // requester 0 wins the first conflict
      cnt_q        <= '0;
    end else begin
      rsp0_valid_q <= rsp0_valid_d;
      rsp1_valid_q <= rsp1_valid_d;
      rsp0_data_q  <= rsp0_data_d;
      rsp1_data_q  <= rsp1_data_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
    end
  end

  assign rsp0_valid   = rsp0_valid_q;
  assign rsp1_valid   = rsp1_valid_q;
  assign rsp0_data    = rsp0_data_q;
  assign rsp1_data    = rsp1_data_q;
  assign conflict_cnt = cnt_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: table of directed vectors plus hand sequences for
// round-robin alternation, counter saturation (narrow counter copy) and async reset.
module tb_alu_share_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0_valid, req1_valid;
  logic        req0_ready, req1_ready;
  logic [3:0]  req0_op, req1_op;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic        rsp0_valid, rsp1_valid;
  logic        rsp0_ready, rsp1_ready;
  logic [31:0] rsp0_data, rsp1_data;
  logic [3:0]  alu_op;
  logic [31:0] alu_a, alu_b, alu_result;
  logic [15:0] conflict_cnt;

  // Narrow-counter copy sharing the same request inputs.
  logic        s_req0_ready, s_req1_ready, s_rsp0_valid, s_rsp1_valid;
  logic [31:0] s_rsp0_data, s_rsp1_data, s_alu_a, s_alu_b, s_alu_result;
  logic [3:0]  s_alu_op;
  logic [3:0]  s_conflict_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] alu_f(input logic [3:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    case (op)
      4'd1:    return a - b;
      4'd2:    return a & b;
      4'd3:    return a | b;
      4'd4:    return a ^ b;
      default: return a + b;
    endcase
  endfunction

  assign alu_result   = alu_f(alu_op, alu_a, alu_b);
  assign s_alu_result = alu_f(s_alu_op, s_alu_a, s_alu_b);

  alu_share_arbiter #(.DATA_W(32), .OP_W(4), .CNT_W(16)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_a(req1_a), .req1_b(req1_b),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_data(rsp0_data),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_data(rsp1_data),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_result(alu_result),
    .conflict_cnt(conflict_cnt)
  );

  alu_share_arbiter #(.DATA_W(32), .OP_W(4), .CNT_W(4)) dut_small (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(s_req0_ready), .req0_op(req0_op),
    .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(s_req1_ready), .req1_op(req1_op),
    .req1_a(req1_a), .req1_b(req1_b),
    .rsp0_valid(s_rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_data(s_rsp0_data),
    .rsp1_valid(s_rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_data(s_rsp1_data),
    .alu_op(s_alu_op), .alu_a(s_alu_a), .alu_b(s_alu_b), .alu_result(s_alu_result),
    .conflict_cnt(s_conflict_cnt)
  );

  typedef struct {
    logic        v0;
    logic [3:0]  op0;
    logic [31:0] a0;
    logic [31:0] b0;
    logic        v1;
    logic [3:0]  op1;
    logic [31:0] a1;
    logic [31:0] b1;
    logic        r0;
    logic        r1;
    logic        g0;
    logic        g1;
    logic [3:0]  eop;
    logic [31:0] ea;
    logic [31:0] eb;
    logic        rv0;
    logic [31:0] rd0;
    logic        rv1;
    logic [31:0] rd1;
    logic [15:0] cnt;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v0, input logic [3:0] op0, input logic [31:0] a0,
                       input logic [31:0] b0, input logic v1, input logic [3:0] op1,
                       input logic [31:0] a1, input logic [31:0] b1, input logic r0,
                       input logic r1);
    req0_valid = v0; req0_op = op0; req0_a = a0; req0_b = b0;
    req1_valid = v1; req1_op = op1; req1_a = a1; req1_b = b1;
    rsp0_ready = r0; rsp1_ready = r1;
  endtask

  task automatic do_reset();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    //          v0 op0 a0     b0     v1 op1 a1     b1     r0 r1 g0 g1 eop ea     eb     rv0 rd0  rv1 rd1    cnt
    vecs[0]  = '{0, 0, 0,     0,     0, 0, 0,     0,     1, 1, 0, 0, 0, 0,     0,     0, 0,    0, 0,     0};
    vecs[1]  = '{1, 0, 5,     7,     0, 0, 0,     0,     1, 1, 1, 0, 0, 5,     7,     1, 12,   0, 0,     0};
    vecs[2]  = '{1, 1, 20,    3,     1, 2, 'hF0,  'h3C,  1, 1, 0, 1, 2, 'hF0,  'h3C,  0, 12,   1, 'h30,  1};
    vecs[3]  = '{1, 1, 20,    3,     1, 2, 'hF0,  'h3C,  1, 1, 1, 0, 1, 20,    3,     1, 17,   0, 'h30,  2};
    vecs[4]  = '{1, 1, 20,    3,     1, 3, 'h0F,  'hF0,  1, 0, 0, 1, 3, 'h0F,  'hF0,  0, 17,   1, 'hFF,  3};
    vecs[5]  = '{1, 1, 20,    3,     1, 3, 'h0F,  'hF0,  1, 0, 1, 0, 1, 20,    3,     1, 17,   1, 'hFF,  3};
    vecs[6]  = '{1, 0, 1,     2,     1, 3, 'h0F,  'hF0,  1, 0, 1, 0, 0, 1,     2,     1, 3,    1, 'hFF,  3};
    vecs[7]  = '{1, 1, 9,     4,     0, 0, 0,     0,     1, 1, 1, 0, 1, 9,     4,     1, 5,    0, 'hFF,  3};
    vecs[8]  = '{0, 0, 0,     0,     0, 0, 0,     0,     0, 1, 0, 0, 0, 0,     0,     1, 5,    0, 'hFF,  3};
    vecs[9]  = '{1, 0, 7,     7,     1, 4, 'hFF,  'h0F,  1, 1, 0, 1, 4, 'hFF,  'h0F,  0, 5,    1, 'hF0,  4};
    vecs[10] = '{0, 0, 0,     0,     1, 0, 1,     1,     1, 0, 0, 0, 0, 0,     0,     0, 5,    1, 'hF0,  4};

    reset = 1'b1;
    do_reset();

    check("reset rsp0_valid", {31'd0, rsp0_valid}, 32'd0);
    check("reset rsp1_valid", {31'd0, rsp1_valid}, 32'd0);
    check("reset rsp0_data", rsp0_data, 32'd0);
    check("reset conflict_cnt", {16'd0, conflict_cnt}, 32'd0);

    for (int i = 0; i < 11; i++) begin
      drive(vecs[i].v0, vecs[i].op0, vecs[i].a0, vecs[i].b0, vecs[i].v1, vecs[i].op1,
            vecs[i].a1, vecs[i].b1, vecs[i].r0, vecs[i].r1);
      #3;
      check($sformatf("v%0d req0_ready", i), {31'd0, req0_ready}, {31'd0, vecs[i].g0});
      check($sformatf("v%0d req1_ready", i), {31'd0, req1_ready}, {31'd0, vecs[i].g1});
      check($sformatf("v%0d alu_op", i), {28'd0, alu_op}, {28'd0, vecs[i].eop});
      check($sformatf("v%0d alu_a", i), alu_a, vecs[i].ea);
      check($sformatf("v%0d alu_b", i), alu_b, vecs[i].eb);
      @(posedge clk);
      #1;
      check($sformatf("v%0d rsp0_valid", i), {31'd0, rsp0_valid}, {31'd0, vecs[i].rv0});
      check($sformatf("v%0d rsp0_data", i), rsp0_data, vecs[i].rd0);
      check($sformatf("v%0d rsp1_valid", i), {31'd0, rsp1_valid}, {31'd0, vecs[i].rv1});
      check($sformatf("v%0d rsp1_data", i), rsp1_data, vecs[i].rd1);
      check($sformatf("v%0d conflict_cnt", i), {16'd0, conflict_cnt}, {16'd0, vecs[i].cnt});
    end

    // Alternation from reset, then saturation of the 4-bit counter copy.
    do_reset();
    for (int i = 0; i < 20; i++) begin
      drive(1, 0, i, 1, 1, 0, 100, i, 1, 1);
      #3;
      check($sformatf("rr%0d req0_ready", i), {31'd0, req0_ready}, {31'd0, (i % 2) == 0});
      check($sformatf("rr%0d req1_ready", i), {31'd0, req1_ready}, {31'd0, (i % 2) == 1});
      @(posedge clk);
      #1;
      check($sformatf("rr%0d conflict_cnt", i), {16'd0, conflict_cnt}, i + 1);
      if (i % 2 == 0) check($sformatf("rr%0d rsp0_data", i), rsp0_data, i + 1);
      else            check($sformatf("rr%0d rsp1_data", i), rsp1_data, 100 + i);
    end
    check("sat small conflict_cnt", {28'd0, s_conflict_cnt}, 32'd15);
    check("sat wide conflict_cnt", {16'd0, conflict_cnt}, 32'd20);

    // Hold rsp1 pending, then assert reset mid-cycle.
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #3;
    check("pre-reset rsp1_valid", {31'd0, rsp1_valid}, 32'd1);
    reset = 1'b1;
    #1;
    check("async reset rsp1_valid", {31'd0, rsp1_valid}, 32'd0);
    check("async reset rsp0_valid", {31'd0, rsp0_valid}, 32'd0);
    check("async reset rsp1_data", rsp1_data, 32'd0);
    check("async reset conflict_cnt", {16'd0, conflict_cnt}, 32'd0);
    check("async reset small cnt", {28'd0, s_conflict_cnt}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
